// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter that sequences one latched command at a time
// onto the APB master's command inputs, with a per-transfer timeout.
module apb_req_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              transfer,
  output logic              wr_rd,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              win;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    win     = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          win     = (req0 && req1) ? ~ptr_q : req1;
          gnt0    = ~win;
          gnt1    = win;
          owner_d = win;
          ptr_d   = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        if (pready) begin
          err_d   = pslverr;
          rdata_d = we_q ? '0 : prdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus-side outputs decode from state only, so reset drops them at once.
  logic busy;
  assign busy     = (state_q == S_BUSY);
  assign transfer = busy;
  assign wr_rd    = busy & we_q;
  assign wr_addr  = (busy && we_q)  ? addr_q  : '0;
  assign rd_addr  = (busy && !we_q) ? addr_q  : '0;
  assign wr_data  = (busy && we_q)  ? wdata_q : '0;
  assign done0    = (state_q == S_DONE) & ~owner_q;
  assign done1    = (state_q == S_DONE) & owner_q;
  assign rdata    = rdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench: directed vector table, reset corner cases and randomized
// transactions checked against a transaction-level arbitration model.
module tb_apb_req_arbiter;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, err, transfer, wr_rd;
  logic [DW-1:0] rdata, wr_data, prdata;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          pready, pslverr;

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .transfer(transfer), .wr_rd(wr_rd),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit last_served;
  logic [DW-1:0] prev_rdata;
  logic          prev_err;

  typedef struct {
    bit            r0, r1, we0, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            busy;      // BUSY cycle carrying pready; 0 = slave never answers
    bit            slverr;
    logic [DW-1:0] prd;
    bit            exp_who;
    int            exp_k;     // cycles from gnt to done
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r0, bit r1, bit w0, bit w1, logic [AW-1:0] a0,
                              logic [AW-1:0] a1, logic [DW-1:0] d0, logic [DW-1:0] d1,
                              int busy, bit se, logic [DW-1:0] prd, bit who, int k,
                              bit e, logic [DW-1:0] rd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we0 = w0; v.we1 = w1; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.busy = busy; v.slverr = se; v.prd = prd;
    v.exp_who = who; v.exp_k = k; v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  // Reference: round-robin winner and transfer outcome from the arbitration rules.
  function automatic vec_t predict(vec_t v, bit last);
    bit timeout;
    bit wwe;
    timeout     = (v.busy < 1) || (v.busy > TO);
    v.exp_who   = (v.r0 && v.r1) ? !last : v.r1;
    wwe         = v.exp_who ? v.we1 : v.we0;
    v.exp_k     = timeout ? TO + 1 : v.busy + 1;
    v.exp_err   = timeout ? 1'b1 : v.slverr;
    v.exp_rdata = (timeout || wwe) ? '0 : v.prd;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int k;
    bit got;
    bit wwe;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    wwe = v.exp_who ? v.we1 : v.we0;
    wa  = v.exp_who ? v.a1 : v.a0;
    wd  = v.exp_who ? v.d1 : v.d0;
    @(negedge clk);
    req0 = v.r0; req1 = v.r1; we0 = v.we0; we1 = v.we1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    pready = 1'b0;
    #1;
    chk({tag, " gnt0"}, 32'(gnt0), 32'(!v.exp_who));
    chk({tag, " gnt1"}, 32'(gnt1), 32'(v.exp_who));
    chk({tag, " idle_transfer"}, 32'(transfer), 0);
    chk({tag, " rdata_hold"}, 32'(rdata), 32'(prev_rdata));
    chk({tag, " err_hold"}, 32'(err), 32'(prev_err));
    last_served = v.exp_who;
    k = 0;
    got = 1'b0;
    while (!got && k < TO + 5) begin
      @(negedge clk);
      k++;
      req0 = 1'b0; req1 = 1'b0;
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      wdata0 = DW'($urandom); wdata1 = DW'($urandom);
      pready  = (v.busy == k);
      pslverr = pready ? v.slverr : 1'($urandom);
      prdata  = pready ? v.prd : DW'($urandom);
      #1;
      if (done0 || done1) begin
        got = 1'b1;
        chk({tag, " latency"}, 32'(k), 32'(v.exp_k));
        chk({tag, " done0"}, 32'(done0), 32'(!v.exp_who));
        chk({tag, " done1"}, 32'(done1), 32'(v.exp_who));
        chk({tag, " rdata"}, 32'(rdata), 32'(v.exp_rdata));
        chk({tag, " err"}, 32'(err), 32'(v.exp_err));
        chk({tag, " done_bus_idle"}, {transfer, wr_rd, wr_addr, rd_addr, wr_data}, 0);
      end else begin
        chk({tag, " transfer"}, 32'(transfer), 1);
        chk({tag, " wr_rd"}, 32'(wr_rd), 32'(wwe));
        chk({tag, " wr_addr"}, 32'(wr_addr), wwe ? 32'(wa) : 0);
        chk({tag, " rd_addr"}, 32'(rd_addr), wwe ? 0 : 32'(wa));
        chk({tag, " wr_data"}, 32'(wr_data), wwe ? 32'(wd) : 0);
      end
    end
    if (!got) chk({tag, " done_seen"}, 0, 1);
    pready = 1'b0;
    prev_rdata = v.exp_rdata;
    prev_err   = v.exp_err;
    $display("txn %s who=%0d k=%0d rdata=%0h err=%0d", tag, v.exp_who, k, rdata, err);
  endtask

  vec_t tbl[9];

  initial begin
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; pready = 0; pslverr = 0; prdata = '0;
    last_served = 1'b1; prev_rdata = '0; prev_err = 1'b0;

    // who, latency, err, rdata below are worked out by hand from the rules
    tbl[0] = mk(1, 0, 1, 0, 9'd2,   9'd0,   8'd23,  8'd0,  2,  0, 8'h00, 0, 3,  0, 8'h00);
    tbl[1] = mk(0, 1, 0, 0, 9'd0,   9'd5,   8'd0,   8'd0,  1,  0, 8'h03, 1, 2,  0, 8'h03);
    tbl[2] = mk(1, 1, 1, 0, 9'd17,  9'd300, 8'h41,  8'h99, 1,  0, 8'h77, 0, 2,  0, 8'h00);
    tbl[3] = mk(1, 1, 1, 0, 9'd18,  9'd301, 8'h42,  8'h98, 1,  0, 8'h66, 1, 2,  0, 8'h66);
    tbl[4] = mk(1, 1, 0, 1, 9'd19,  9'd302, 8'h43,  8'h97, 1,  0, 8'h55, 0, 2,  0, 8'h55);
    tbl[5] = mk(1, 0, 0, 0, 9'd33,  9'd0,   8'h00,  8'h00, 3,  1, 8'hAA, 0, 4,  1, 8'hAA);
    tbl[6] = mk(0, 1, 0, 1, 9'd0,   9'd511, 8'h00,  8'hF0, 0,  0, 8'h00, 1, 17, 1, 8'h00);
    tbl[7] = mk(1, 0, 0, 0, 9'd256, 9'd0,   8'h00,  8'h00, 0,  0, 8'h12, 0, 17, 1, 8'h00);
    tbl[8] = mk(1, 1, 1, 0, 9'd1,   9'd99,  8'h01,  8'h00, 16, 0, 8'h5C, 1, 17, 0, 8'h5C);

    // Reset held two cycles: everything quiet.
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {gnt0, gnt1, done0, done1, rdata, err, transfer, wr_rd,
                          wr_addr, rd_addr, wr_data}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("post_reset_no_gnt", {gnt0, gnt1, transfer, done0, done1}, 0);
    end

    for (int i = 0; i < 9; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Reset during BUSY: transfer falls asynchronously and no done follows.
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 9'd7; wdata0 = 8'h3C;
    #1;
    chk("rst_mid gnt0", 32'(gnt0), 1);
    @(negedge clk);
    req0 = 0;
    #1;
    chk("rst_mid transfer_before", 32'(transfer), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid transfer_async", 32'(transfer), 0);
    chk("rst_mid bus_zero", {wr_rd, wr_addr, wr_data, rdata, err}, 0);
    pready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid no_done", {done0, done1, transfer}, 0);
    pready = 1'b0;
    reset = 1'b1;
    last_served = 1'b1; prev_rdata = '0; prev_err = 1'b0;
    run(predict(mk(0, 1, 0, 0, 9'd0, 9'd44, 8'd0, 8'd0, 2, 0, 8'hE1, 0, 0, 0, 8'd0), last_served),
        "rst_req1");
    @(negedge clk);
    #1;
    chk("rst_req1 rdata_stable", 32'(rdata), 32'hE1);

    // Randomized traffic against the model.
    for (int i = 0; i < 30; i++) begin
      vec_t v;
      int pat;
      pat = $urandom_range(1, 3);
      v = mk(pat[0], pat[1], 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
             DW'($urandom), DW'($urandom), $urandom_range(0, 6), 1'($urandom),
             DW'($urandom), 0, 0, 0, 8'd0);
      run(predict(v, last_served), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
